// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out transmitter, MSB first, with bit strobe
//
// Ports:
//   clk_sr      in   clock; all state updates on the rising edge
//   rst         in   synchronous reset, active-high
//   load_data   in   [WIDTH-1:0] parallel word to transmit
//   load_valid  in   load_data is valid
//   load_ready  out  word accepted this cycle when load_valid && load_ready
//   data_out    out  serial data, registered
//   bit_valid   out  high while data_out carries a frame bit
//   bit_tick    out  pulse in the final cycle of each bit period (receiver shift enable)
//   frame_start out  high in the first cycle of a frame's first bit
//   done        out  high in the final cycle of a frame's last bit
//
// Optional feature macro: SERIAL_PARITY_EN (appends an even-parity bit period)

module piso_serializer #(
    parameter int WIDTH = 8,
    parameter int DIV   = 1
) (
    input  logic             clk_sr,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             data_out,
    output logic             bit_valid,
    output logic             bit_tick,
    output logic             frame_start,
    output logic             done
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

`ifdef SERIAL_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
    logic parity;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [DW-1:0]    div_cnt;
    logic [BW-1:0]    bit_cnt;

    logic last_div;
    logic last_bit;
    logic end_frame;
    logic accept;

    assign last_div = (div_cnt == DW'(DIV - 1));
    assign last_bit = (bit_cnt == BW'(WIDTH - 1));

`ifdef SERIAL_PARITY_EN
    assign end_frame = (state == PAR) && last_div;
`else
    assign end_frame = (state == SHIFT) && last_bit && last_div;
`endif

    assign bit_tick   = (state != IDLE) && last_div;
    assign done       = end_frame;
    assign load_ready = (state == IDLE) || end_frame;
    assign accept     = load_valid && load_ready;

    always_ff @(posedge clk_sr) begin
        if (rst) begin
            state       <= IDLE;
            sreg        <= '0;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            data_out    <= 1'b0;
            bit_valid   <= 1'b0;
            frame_start <= 1'b0;
`ifdef SERIAL_PARITY_EN
            parity      <= 1'b0;
`endif
        end else begin
            frame_start <= accept;
            if (accept) begin
                // New word (from IDLE or at the end of the previous frame)
                state     <= SHIFT;
                sreg      <= load_data;
                div_cnt   <= '0;
                bit_cnt   <= '0;
                data_out  <= load_data[WIDTH-1];
                bit_valid <= 1'b1;
`ifdef SERIAL_PARITY_EN
                parity    <= ^load_data;
`endif
            end else begin
                case (state)
                    SHIFT: begin
                        if (last_div) begin
                            div_cnt <= '0;
                            sreg    <= {sreg[WIDTH-2:0], 1'b0};
                            if (last_bit) begin
                                bit_cnt <= '0;
`ifdef SERIAL_PARITY_EN
                                state    <= PAR;
                                data_out <= parity;
`else
                                state     <= IDLE;
                                data_out  <= 1'b0;
                                bit_valid <= 1'b0;
`endif
                            end else begin
                                bit_cnt  <= bit_cnt + 1'b1;
                                // Next MSB after the shift
                                data_out <= sreg[WIDTH-2];
                            end
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
`ifdef SERIAL_PARITY_EN
                    PAR: begin
                        if (last_div) begin
                            state     <= IDLE;
                            div_cnt   <= '0;
                            data_out  <= 1'b0;
                            bit_valid <= 1'b0;
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
`endif
                    default: begin
                        state     <= IDLE;
                        data_out  <= 1'b0;
                        bit_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - directed self-checking bench for piso_serializer (DIV=1 and DIV=4)

module tb_piso_serializer;

`ifdef SERIAL_PARITY_EN
    localparam int FB = 9;
`else
    localparam int FB = 8;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0] a_load_data, b_load_data;
    logic a_load_valid, a_load_ready, a_data_out, a_bit_valid, a_bit_tick, a_frame_start, a_done;
    logic b_load_valid, b_load_ready, b_data_out, b_bit_valid, b_bit_tick, b_frame_start, b_done;

    int vectors = 0;
    int miscompares = 0;

    piso_serializer #(.WIDTH(8), .DIV(1)) u_a (
        .clk_sr(clk), .rst(rst), .load_data(a_load_data), .load_valid(a_load_valid),
        .load_ready(a_load_ready), .data_out(a_data_out), .bit_valid(a_bit_valid),
        .bit_tick(a_bit_tick), .frame_start(a_frame_start), .done(a_done)
    );

    piso_serializer #(.WIDTH(8), .DIV(4)) u_b (
        .clk_sr(clk), .rst(rst), .load_data(b_load_data), .load_valid(b_load_valid),
        .load_ready(b_load_ready), .data_out(b_data_out), .bit_valid(b_bit_valid),
        .bit_tick(b_bit_tick), .frame_start(b_frame_start), .done(b_done)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic a_idle_check();
        check("a_idle_data", a_data_out, 0);
        check("a_idle_bv", a_bit_valid, 0);
        check("a_idle_ready", a_load_ready, 1);
        check("a_idle_tick", a_bit_tick, 0);
        check("a_idle_done", a_done, 0);
    endtask

    // Present a word in IDLE; returns at the negedge of the frame's first cycle.
    task automatic a_start(input logic [7:0] w);
        a_load_valid = 1'b1;
        a_load_data  = w;
        check("a_ready_idle", a_load_ready, 1);
        @(negedge clk);
        a_load_valid = 1'b0;
    endtask

    // Walk one DIV=1 frame; optionally chain the next word in the final cycle.
    task automatic a_frame(input logic [7:0] w, input logic par,
                           input logic chain, input logic [7:0] nxt);
        logic [7:0] rx;
        logic       eb;
        rx = 8'h00;
        for (int i = 0; i < FB; i++) begin
            eb = (i < 8) ? w[7-i] : par;
            check("a_bit", a_data_out, eb);
            check("a_bv", a_bit_valid, 1);
            check("a_tick", a_bit_tick, 1);
            check("a_fstart", a_frame_start, i == 0);
            check("a_done", a_done, i == FB - 1);
            check("a_ready", a_load_ready, i == FB - 1);
            if (a_bit_tick && i < 8) rx = {rx[6:0], a_data_out};
            a_load_valid = (i == FB - 1) && chain;
            a_load_data  = nxt;
            @(negedge clk);
        end
        a_load_valid = 1'b0;
        check("a_rx_word", rx, w);
    endtask

    initial begin
        int ticks;
        int fl;
        logic eb;

        // Reset with load_valid asserted: reset must win.
        rst = 1'b1;
        a_load_valid = 1'b1; a_load_data = 8'hFF;
        b_load_valid = 1'b1; b_load_data = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_data", a_data_out, 0);
            check("rst_bv", a_bit_valid, 0);
            check("rst_ready", a_load_ready, 1);
            check("rst_fstart", a_frame_start, 0);
            check("rst_b_fstart", b_frame_start, 0);
            check("rst_b_ready", b_load_ready, 1);
        end
        rst = 1'b0;
        a_load_valid = 1'b0;
        b_load_valid = 1'b0;
        @(negedge clk);
        a_idle_check();

        // Single word 0xA5 (parity 0)
        a_start(8'hA5);
        a_frame(8'hA5, 1'b0, 1'b0, 8'h00);
        a_idle_check();

        // Back-to-back 0x3C then 0xC3 (both parity 0)
        a_start(8'h3C);
        a_frame(8'h3C, 1'b0, 1'b1, 8'hC3);
        a_frame(8'hC3, 1'b0, 1'b0, 8'h00);
        a_idle_check();

`ifdef SERIAL_PARITY_EN
        a_start(8'h07);
        a_frame(8'h07, 1'b1, 1'b0, 8'h00);
        a_start(8'h03);
        a_frame(8'h03, 1'b0, 1'b0, 8'h00);
        a_idle_check();
`endif

        // Reset after 3 bits of 0xF0
        a_start(8'hF0);
        for (int i = 0; i < 3; i++) begin
            check("mid_bit", a_data_out, 1);
            if (i < 2) @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_data", a_data_out, 0);
        check("mid_rst_ready", a_load_ready, 1);
        check("mid_rst_done", a_done, 0);
        check("mid_rst_bv", a_bit_valid, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mid_no_done", a_done, 0);
            check("mid_no_bv", a_bit_valid, 0);
        end
        a_start(8'hFF);
        a_frame(8'hFF, 1'b0, 1'b0, 8'h00);
        a_idle_check();

        // DIV=4, word 0x81 (parity 0); a stray load_valid while busy must be ignored
        fl = FB * 4;
        ticks = 0;
        b_load_valid = 1'b1;
        b_load_data  = 8'h81;
        check("b_ready_idle", b_load_ready, 1);
        @(negedge clk);
        b_load_valid = 1'b0;
        for (int c = 1; c <= fl; c++) begin
            eb = ((c - 1) / 4 < 8) ? b_load_data[7 - (c - 1) / 4] : 1'b0;
            check("b_bit", b_data_out, eb);
            check("b_bv", b_bit_valid, 1);
            check("b_tick", b_bit_tick, (c % 4) == 0);
            check("b_ready", b_load_ready, c == fl);
            check("b_done", b_done, c == fl);
            check("b_fstart", b_frame_start, c == 1);
            if (b_bit_tick) ticks++;
            if (c == 1) begin
                b_load_valid = 1'b1;
                b_load_data  = 8'h81;
            end
            if (c == fl - 2) b_load_valid = 1'b0;
            @(negedge clk);
        end
        check("b_tick_count", ticks, FB);
        check("b_idle_bv", b_bit_valid, 0);
        check("b_idle_data", b_data_out, 0);
        check("b_idle_ready", b_load_ready, 1);
        check("b_idle_fstart", b_frame_start, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
